// File: rtl/motctl_arbiter.sv
// motctl_arbiter: owns the Rojobot MotCtl_in byte and arbitrates it between
// PicoBlaze motor writes and a dead-zoned, debounced, watchdog-protected
// accelerometer tilt-drive path. Every ownership change passes through a
// timed all-stop handoff.
module motctl_arbiter #(
    parameter int DEADZONE   = 16,
    parameter int SPD_SHIFT  = 4,
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 50_000_000,
    parameter int HANDOFF    = 1_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tilt_en_i,
    input  logic [7:0] pb_motctl_i,
    input  logic       pb_motctl_wr_i,
    input  logic [8:0] accel_x_i,
    input  logic [8:0] accel_y_i,
    input  logic       upd_sysregs_i,
    output logic [7:0] motctl_o,
    output logic [7:0] arb_status_o
);

    localparam int HoW = $clog2(HANDOFF + 1);
    localparam int WdW = $clog2(TIMEOUT + 1);
    localparam int StW = $clog2(STABLE_CNT + 1);

    typedef enum logic [1:0] {
        PB_OWN   = 2'd0,
        TO_TILT  = 2'd1,
        TILT_OWN = 2'd2,
        TO_PB    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [HoW-1:0]   hoCnt_q, hoCnt_d;
    logic [7:0]       motctl_q, motctl_d;
    logic             pendValid_q, pendValid_d;
    logic [7:0]       pendData_q, pendData_d;
    logic [WdW-1:0]   wdCnt_q, wdCnt_d;
    logic             toFlag_q, toFlag_d;
    logic [StW-1:0]   stableCnt_q, stableCnt_d;
    logic [7:0]       prevCmd_q, prevCmd_d;

    logic             c1Valid_q;
    logic [8:0]       xS_q, yS_q;
    logic             c2Valid_q;
    logic [7:0]       cmd_q;

    logic [8:0]       magX, magY;
    logic             xActive, yActive;
    logic [2:0]       spdX, spdY, lSpd, rSpd;
    logic [7:0]       cmdComb;
    logic [StW-1:0]   newStable;
    logic             wdExpired;

    function automatic logic [2:0] spdOf(input logic [8:0] m);
        logic [8:0] s;
        s = (m - 9'(DEADZONE)) >> SPD_SHIFT;
        if (s >= 9'd6) begin
            return 3'd7;
        end
        return s[2:0] + 3'd1;
    endfunction

    // Tilt pipeline stages 1 and 2: capture the sample, then register the derived command.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            c1Valid_q <= 1'b0;
            xS_q      <= 9'd0;
            yS_q      <= 9'd0;
            c2Valid_q <= 1'b0;
            cmd_q     <= 8'h00;
        end else if (state_q != TILT_OWN) begin
            c1Valid_q <= 1'b0;
            c2Valid_q <= 1'b0;
        end else begin
            c1Valid_q <= upd_sysregs_i;
            if (upd_sysregs_i) begin
                xS_q <= accel_x_i;
                yS_q <= accel_y_i;
            end
            c2Valid_q <= c1Valid_q;
            if (c1Valid_q) begin
                cmd_q <= cmdComb;
            end
        end
    end

    // Convert a captured tilt sample into a motor command: forward/back drive with optional turn, or spin.
    always_comb begin
        magX    = (xS_q >= 9'd256) ? (xS_q - 9'd256) : (9'd256 - xS_q);
        magY    = (yS_q >= 9'd256) ? (yS_q - 9'd256) : (9'd256 - yS_q);
        xActive = magX > 9'(DEADZONE);
        yActive = magY > 9'(DEADZONE);
        spdX    = spdOf(magX);
        spdY    = spdOf(magY);
        lSpd    = spdY;
        rSpd    = spdY;
        cmdComb = 8'h00;
        if (yActive) begin
            if (xActive) begin
                if (xS_q > 9'd256) begin
                    rSpd = spdY >> 1;
                end else begin
                    lSpd = spdY >> 1;
                end
            end
            cmdComb = {lSpd, (yS_q > 9'd256), rSpd, (yS_q > 9'd256)};
        end else if (xActive) begin
            cmdComb = {spdX, (xS_q > 9'd256), spdX, ~(xS_q > 9'd256)};
        end
    end

    // Ownership FSM, handoff timing, pending PicoBlaze write, debounce and watchdog next-state.
    always_comb begin
        state_d     = state_q;
        hoCnt_d     = hoCnt_q;
        motctl_d    = motctl_q;
        pendValid_d = pendValid_q;
        pendData_d  = pendData_q;
        wdCnt_d     = '0;
        toFlag_d    = 1'b0;
        stableCnt_d = '0;
        prevCmd_d   = prevCmd_q;
        wdExpired   = (wdCnt_q >= WdW'(TIMEOUT)) && !upd_sysregs_i;
        newStable   = StW'(1);
        if (cmd_q == prevCmd_q) begin
            newStable = (stableCnt_q < StW'(STABLE_CNT)) ? stableCnt_q + StW'(1) : stableCnt_q;
        end

        case (state_q)
            PB_OWN: begin
                if (tilt_en_i) begin
                    state_d  = TO_TILT;
                    hoCnt_d  = '0;
                    motctl_d = 8'h00;
                end else if (pb_motctl_wr_i) begin
                    motctl_d = pb_motctl_i;
                end
            end
            TO_TILT: begin
                motctl_d = 8'h00;
                if (!tilt_en_i) begin
                    state_d     = TO_PB;
                    hoCnt_d     = '0;
                    pendValid_d = 1'b0;
                end else if (hoCnt_q == HoW'(HANDOFF - 1)) begin
                    state_d   = TILT_OWN;
                    hoCnt_d   = '0;
                    prevCmd_d = 8'h00;
                end else begin
                    hoCnt_d = hoCnt_q + HoW'(1);
                end
            end
            TILT_OWN: begin
                if (!tilt_en_i) begin
                    state_d     = TO_PB;
                    hoCnt_d     = '0;
                    motctl_d    = 8'h00;
                    pendValid_d = 1'b0;
                end else begin
                    stableCnt_d = stableCnt_q;
                    toFlag_d    = toFlag_q;
                    if (upd_sysregs_i) begin
                        wdCnt_d  = '0;
                        toFlag_d = 1'b0;
                    end else if (wdCnt_q < WdW'(TIMEOUT)) begin
                        wdCnt_d = wdCnt_q + WdW'(1);
                    end else begin
                        wdCnt_d = wdCnt_q;
                    end
                    if (wdExpired) begin
                        motctl_d    = 8'h00;
                        toFlag_d    = 1'b1;
                        stableCnt_d = '0;
                    end else if (c2Valid_q) begin
                        stableCnt_d = newStable;
                        prevCmd_d   = cmd_q;
                        if (newStable >= StW'(STABLE_CNT)) begin
                            motctl_d = cmd_q;
                        end
                    end
                end
            end
            TO_PB: begin
                motctl_d = 8'h00;
                if (pb_motctl_wr_i) begin
                    pendValid_d = 1'b1;
                    pendData_d  = pb_motctl_i;
                end
                if (hoCnt_q == HoW'(HANDOFF - 1)) begin
                    state_d = PB_OWN;
                    hoCnt_d = '0;
                    if (pb_motctl_wr_i) begin
                        motctl_d = pb_motctl_i;
                    end else if (pendValid_q) begin
                        motctl_d = pendData_q;
                    end
                end else begin
                    hoCnt_d = hoCnt_q + HoW'(1);
                end
            end
            default: begin
                state_d  = PB_OWN;
                motctl_d = 8'h00;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= PB_OWN;
            hoCnt_q     <= '0;
            motctl_q    <= 8'h00;
            pendValid_q <= 1'b0;
            pendData_q  <= 8'h00;
            wdCnt_q     <= '0;
            toFlag_q    <= 1'b0;
            stableCnt_q <= '0;
            prevCmd_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            hoCnt_q     <= hoCnt_d;
            motctl_q    <= motctl_d;
            pendValid_q <= pendValid_d;
            pendData_q  <= pendData_d;
            wdCnt_q     <= wdCnt_d;
            toFlag_q    <= toFlag_d;
            stableCnt_q <= stableCnt_d;
            prevCmd_q   <= prevCmd_d;
        end
    end

    assign motctl_o     = motctl_q;
    assign arb_status_o = {(state_q == TILT_OWN), state_q, toFlag_q, 4'b0000};

endmodule
